// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//   Instruction fetch sequencer. It captures the PC in ADDR, issues a single
//   16-bit memory read in FETCH, then holds the instruction in ir until the
//   consumer acknowledges it. A flush (redirect) aborts the current sequence.
//   If a read is already outstanding, the read is drained and its data is
//   discarded, so the bus handshake is never broken.
//
//   Optional feature: define FETCH_TIMEOUT_EN to bound the wait for mem_ready
//   to TIMEOUT_CYCLES cycles. On expiry the unit pulses bus_err and returns to
//   IDLE. When the macro is undefined the wait is unbounded and bus_err is
//   tied low.
//
// Ports
//   clk        in   1   clock, all state on rising edge
//   reset      in   1   synchronous, active-high reset
//   run        in   1   fetch enable; no new fetch starts while low
//   flush      in   1   redirect strobe (PC is loaded externally that cycle)
//   pc_in      in  16   current PC value
//   mem_rd     out  1   memory read request (FETCH / DRAIN only)
//   mem_addr   out 16   read address (captured PC)
//   mem_ready  in   1   read data valid, completes the request
//   mem_rdata  in  16   read data
//   ir         out 16   instruction register
//   ir_valid   out  1   ir holds an unconsumed instruction
//   ir_ack     in   1   downstream consumed ir
//   load_pc    out  1   one-cycle PC advance strobe per completed fetch
//   pc_sel     out  2   PC source select, always PC+2 (2'b00)
//   bus_err    out  1   one-cycle fetch-timeout pulse
// -----------------------------------------------------------------------------
module fetch_unit #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    input  logic        flush,
    input  logic [15:0] pc_in,
    output logic        mem_rd,
    output logic [15:0] mem_addr,
    input  logic        mem_ready,
    input  logic [15:0] mem_rdata,
    output logic [15:0] ir,
    output logic        ir_valid,
    input  logic        ir_ack,
    output logic        load_pc,
    output logic [1:0]  pc_sel,
    output logic        bus_err
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ADDR  = 3'd1,
        S_FETCH = 3'd2,
        S_DRAIN = 3'd3,
        S_HOLD  = 3'd4
    } state_t;

    state_t      state_reg;
    logic [15:0] addr_reg;
    logic [15:0] ir_reg;
    logic        mem_rd_reg;
    logic        ir_valid_reg;
    logic        load_pc_reg;
    logic        bus_err_reg;
    logic        tmo_hit;

`ifdef FETCH_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

    logic [CNT_W-1:0] tmo_cnt_reg;
    logic             in_bus;
    logic             to_drain;

    assign in_bus   = (state_reg == S_FETCH) || (state_reg == S_DRAIN);
    assign to_drain = (state_reg == S_FETCH) && flush && !mem_ready;

    // Held at zero outside the bus states, so it starts from zero on entry to
    // FETCH. The FETCH->DRAIN hop restarts it so the drain gets a full budget.
    always_ff @(posedge clk) begin
        if (reset || !in_bus || to_drain) begin
            tmo_cnt_reg <= '0;
        end else if (!mem_ready) begin
            tmo_cnt_reg <= tmo_cnt_reg + CNT_W'(1);
        end
    end

    // The last permitted waiting cycle: mem_rd has been high TIMEOUT_CYCLES cycles.
    assign tmo_hit = in_bus && !mem_ready &&
                     (tmo_cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= S_IDLE;
            addr_reg     <= 16'h0000;
            ir_reg       <= 16'h0000;
            mem_rd_reg   <= 1'b0;
            ir_valid_reg <= 1'b0;
            load_pc_reg  <= 1'b0;
            bus_err_reg  <= 1'b0;
        end else begin
            load_pc_reg <= 1'b0;
            bus_err_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (run) begin
                        state_reg <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    addr_reg <= pc_in;
                    if (flush) begin
                        state_reg <= S_ADDR;          // re-sample the redirected PC
                    end else if (run) begin
                        state_reg  <= S_FETCH;
                        mem_rd_reg <= 1'b1;
                    end else begin
                        state_reg <= S_IDLE;
                    end
                end
                S_FETCH: begin
                    if (mem_ready) begin
                        mem_rd_reg <= 1'b0;
                        if (flush) begin
                            state_reg <= S_ADDR;      // stale data dropped
                        end else begin
                            ir_reg       <= mem_rdata;
                            load_pc_reg  <= 1'b1;
                            ir_valid_reg <= 1'b1;
                            state_reg    <= S_HOLD;
                        end
                    end else if (flush) begin
                        state_reg <= S_DRAIN;         // read still owed to the bus
                    end else if (tmo_hit) begin
                        mem_rd_reg  <= 1'b0;
                        bus_err_reg <= 1'b1;
                        state_reg   <= S_IDLE;
                    end
                end
                S_DRAIN: begin
                    if (mem_ready) begin
                        mem_rd_reg <= 1'b0;
                        state_reg  <= S_ADDR;
                    end else if (tmo_hit) begin
                        mem_rd_reg  <= 1'b0;
                        bus_err_reg <= 1'b1;
                        state_reg   <= S_IDLE;
                    end
                end
                S_HOLD: begin
                    if (flush) begin
                        ir_valid_reg <= 1'b0;
                        state_reg    <= S_ADDR;
                    end else if (ir_ack) begin
                        ir_valid_reg <= 1'b0;
                        state_reg    <= run ? S_ADDR : S_IDLE;
                    end
                end
                default: begin
                    state_reg    <= S_IDLE;
                    mem_rd_reg   <= 1'b0;
                    ir_valid_reg <= 1'b0;
                end
            endcase
        end
    end

    assign mem_rd   = mem_rd_reg;
    assign mem_addr = addr_reg;
    assign ir       = ir_reg;
    assign ir_valid = ir_valid_reg;
    assign load_pc  = load_pc_reg;
    assign bus_err  = bus_err_reg;
    assign pc_sel   = 2'b00;

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
//   Directed plus randomized bench for fetch_unit. The bench owns the PC
//   register (advanced by load_pc, overwritten by flush) and a memory whose
//   contents are a fixed function of the address. The expected fetch address
//   (exp_pc), expected instruction, and expected number of load_pc pulses are
//   tracked from the transaction rules alone.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        run;
    logic        flush;
    logic [15:0] pc_in;
    logic        mem_rd;
    logic [15:0] mem_addr;
    logic        mem_ready;
    logic [15:0] mem_rdata;
    logic [15:0] ir;
    logic        ir_valid;
    logic        ir_ack;
    logic        load_pc;
    logic [1:0]  pc_sel;
    logic        bus_err;

    logic [15:0] pc_reg;
    logic [15:0] flush_target;
    logic [15:0] exp_pc;
    logic [15:0] last_ir;
    int          n_checks  = 0;
    int          n_errors  = 0;
    int          lp_cnt    = 0;
    int          exp_loads = 0;

    always #5 clk = ~clk;

    fetch_unit #(.TIMEOUT_CYCLES(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .run       (run),
        .flush     (flush),
        .pc_in     (pc_in),
        .mem_rd    (mem_rd),
        .mem_addr  (mem_addr),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata),
        .ir        (ir),
        .ir_valid  (ir_valid),
        .ir_ack    (ir_ack),
        .load_pc   (load_pc),
        .pc_sel    (pc_sel),
        .bus_err   (bus_err)
    );

    // External PC stage: redirect wins over the sequential advance.
    always @(posedge clk) begin
        if (reset)
            pc_reg <= 16'h0000;
        else if (flush)
            pc_reg <= flush_target;
        else if (load_pc)
            pc_reg <= pc_reg + 16'd2;
    end
    assign pc_in = pc_reg;

    always @(negedge clk) begin
        if (load_pc === 1'b1)
            lp_cnt <= lp_cnt + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] memval(input logic [15:0] a);
        if (a == 16'h0000)
            return 16'h1234;
        return (a * 16'h9E37) ^ 16'h5A5A;
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for the read request, then check address and pc_sel.
    task automatic wait_rd();
        int n;
        n = 0;
        while (mem_rd !== 1'b1 && n < 10) begin
            tick();
            n++;
        end
        check("rd_start", 16'(mem_rd), 16'd1);
        check("addr", mem_addr, exp_pc);
        check("pc_sel", 16'(pc_sel), 16'd0);
    endtask

    // Memory withholds mem_ready; request and address must stay put.
    task automatic wait_lat(input int lat, input logic [15:0] a);
        for (int i = 0; i < lat; i++) begin
            tick();
            check("rd_held", 16'(mem_rd), 16'd1);
            check("addr_held", mem_addr, a);
        end
    endtask

    task automatic complete_ok(input int hold, input logic run_after);
        mem_ready = 1'b1;
        mem_rdata = memval(exp_pc);
        tick();
        mem_ready = 1'b0;
        mem_rdata = 16'($urandom);
        last_ir   = memval(exp_pc);
        exp_loads++;
        check("ir_valid_set", 16'(ir_valid), 16'd1);
        check("ir_data", ir, last_ir);
        check("load_pc_pulse", 16'(load_pc), 16'd1);
        check("rd_drop", 16'(mem_rd), 16'd0);
        for (int i = 0; i < hold; i++) begin
            tick();
            check("ir_valid_hold", 16'(ir_valid), 16'd1);
            check("load_pc_once", 16'(load_pc), 16'd0);
        end
        run    = run_after;
        ir_ack = 1'b1;
        tick();
        ir_ack = 1'b0;
        exp_pc = exp_pc + 16'd2;
        check("ir_valid_clr", 16'(ir_valid), 16'd0);
        check("load_count", 16'(lp_cnt), 16'(exp_loads));
    endtask

    // After a discarded read: nothing may have reached ir or the PC stage.
    task automatic check_discard();
        check("disc_rd", 16'(mem_rd), 16'd0);
        check("disc_valid", 16'(ir_valid), 16'd0);
        check("disc_load", 16'(load_pc), 16'd0);
        check("disc_ir", ir, last_ir);
    endtask

    task automatic op_normal(input int lat, input int hold, input logic run_after);
        run = 1'b1;
        wait_rd();
        wait_lat(lat, exp_pc);
        complete_ok(hold, run_after);
    endtask

    task automatic op_drain(input int lat1, input int lat2, input logic [15:0] tgt);
        logic [15:0] a;
        run = 1'b1;
        wait_rd();
        a = exp_pc;
        wait_lat(lat1, a);
        flush = 1'b1;
        flush_target = tgt;
        tick();
        check("drain_rd", 16'(mem_rd), 16'd1);
        check("drain_addr", mem_addr, a);
        // flush stays high into the first DRAIN cycle: it must change nothing
        for (int i = 0; i < lat2; i++) begin
            tick();
            flush = 1'b0;
            check("drain_rd_held", 16'(mem_rd), 16'd1);
            check("drain_addr_held", mem_addr, a);
        end
        flush = 1'b0;
        mem_ready = 1'b1;
        mem_rdata = 16'($urandom);
        tick();
        mem_ready = 1'b0;
        exp_pc = tgt;
        check_discard();
        check("drain_loads", 16'(lp_cnt), 16'(exp_loads));
    endtask

    task automatic op_coinc(input int lat, input logic [15:0] tgt);
        run = 1'b1;
        wait_rd();
        wait_lat(lat, exp_pc);
        flush = 1'b1;
        flush_target = tgt;
        mem_ready = 1'b1;
        mem_rdata = 16'($urandom);
        tick();
        flush = 1'b0;
        mem_ready = 1'b0;
        exp_pc = tgt;
        check_discard();
    endtask

    task automatic op_hold_flush(input int lat, input logic [15:0] tgt);
        run = 1'b1;
        wait_rd();
        wait_lat(lat, exp_pc);
        mem_ready = 1'b1;
        mem_rdata = memval(exp_pc);
        tick();
        mem_ready = 1'b0;
        last_ir = memval(exp_pc);
        exp_loads++;
        check("hf_valid", 16'(ir_valid), 16'd1);
        check("hf_ir", ir, last_ir);
        flush = 1'b1;
        ir_ack = 1'b1;
        flush_target = tgt;
        tick();
        flush = 1'b0;
        ir_ack = 1'b0;
        exp_pc = tgt;
        check("hf_valid_clr", 16'(ir_valid), 16'd0);
        check("hf_loads", 16'(lp_cnt), 16'(exp_loads));
    endtask

    task automatic op_run_low(input int lat, input logic [15:0] tgt);
        run = 1'b1;
        wait_rd();
        run = 1'b0;                       // must not abort the read
        wait_lat(lat, exp_pc);
        complete_ok(0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("idle_rd", 16'(mem_rd), 16'd0);
        end
        flush = 1'b1;                     // ignored by the unit while idle
        flush_target = tgt;
        tick();
        flush = 1'b0;
        exp_pc = tgt;
        check("idle_flush_rd", 16'(mem_rd), 16'd0);
        check("idle_flush_valid", 16'(ir_valid), 16'd0);
    endtask

    initial begin
        int op;
        int lat;
        int lat2;
        int hold;
        int cnt;
        logic [15:0] tgt;

        reset = 1'b1; run = 1'b0; flush = 1'b0; mem_ready = 1'b0;
        ir_ack = 1'b0; mem_rdata = 16'h0000; flush_target = 16'h0000;
        exp_pc = 16'h0000; last_ir = 16'h0000;
        tick();
        tick();
        check("rst_rd", 16'(mem_rd), 16'd0);
        check("rst_valid", 16'(ir_valid), 16'd0);
        check("rst_load", 16'(load_pc), 16'd0);
        check("rst_berr", 16'(bus_err), 16'd0);
        check("rst_addr", mem_addr, 16'h0000);
        check("rst_ir", ir, 16'h0000);
        check("rst_pcsel", 16'(pc_sel), 16'd0);
        reset = 1'b0;
        run = 1'b1;
        tick();
        check("post_rst_rd", 16'(mem_rd), 16'd0);
        check("post_rst_valid", 16'(ir_valid), 16'd0);
        check("post_rst_load", 16'(load_pc), 16'd0);
        check("post_rst_addr", mem_addr, 16'h0000);

        // First fetch at 0x0000 (data 0x1234, ready two cycles after request),
        // then two back-to-back fetches at 0x0002 and 0x0004.
        op_normal(2, 1, 1'b1);
        op_normal(1, 1, 1'b1);
        op_normal(0, 1, 1'b1);

        // Redirect while a read is pending; next fetch must come from 0x3000.
        op_drain(1, 2, 16'h3000);
        op_normal(1, 0, 1'b1);

        // Redirect together with ir_ack in HOLD.
        op_hold_flush(0, 16'h4A20);
        op_normal(0, 0, 1'b1);

        // Redirect coincident with mem_ready.
        op_coinc(1, 16'h0100);
        op_normal(2, 0, 1'b1);

        // Reset in the middle of a read.
        run = 1'b1;
        wait_rd();
        reset = 1'b1;
        tick();
        check("midrst_rd", 16'(mem_rd), 16'd0);
        check("midrst_ir", ir, 16'h0000);
        check("midrst_valid", 16'(ir_valid), 16'd0);
        reset = 1'b0;
        exp_pc = 16'h0000;
        last_ir = 16'h0000;
        op_normal(1, 0, 1'b1);

        // Randomized mix of all transaction kinds.
        for (int k = 0; k < 40; k++) begin
            op   = $urandom_range(0, 4);
            lat  = $urandom_range(0, 4);
            lat2 = $urandom_range(0, 3);
            hold = $urandom_range(0, 2);
            tgt  = 16'($urandom) & 16'hFFFE;
            case (op)
                0: op_normal(lat, hold, 1'($urandom_range(0, 1)));
                1: op_drain(lat, lat2, tgt);
                2: op_coinc(lat, tgt);
                3: op_hold_flush(lat, tgt);
                default: op_run_low(lat, tgt);
            endcase
        end

`ifdef FETCH_TIMEOUT_EN
        // mem_ready never arrives: 16 cycles of mem_rd, then a bus_err pulse.
        run = 1'b1;
        wait_rd();
        run = 1'b0;
        cnt = 0;
        while (mem_rd === 1'b1 && cnt < 40) begin
            cnt++;
            tick();
        end
        check("tmo_rd_cycles", 16'(cnt), 16'd16);
        check("tmo_berr", 16'(bus_err), 16'd1);
        check("tmo_rd", 16'(mem_rd), 16'd0);
        tick();
        check("tmo_berr_pulse", 16'(bus_err), 16'd0);
        check("tmo_ir", ir, last_ir);
        check("tmo_valid", 16'(ir_valid), 16'd0);
        check("tmo_loads", 16'(lp_cnt), 16'(exp_loads));
        tick();
        check("tmo_idle_rd", 16'(mem_rd), 16'd0);
        op_normal(1, 0, 1'b1);
`else
        // Without the timeout the unit waits indefinitely and never errors.
        run = 1'b1;
        wait_rd();
        for (int i = 0; i < 24; i++) begin
            tick();
            check("wait_rd", 16'(mem_rd), 16'd1);
            check("wait_berr", 16'(bus_err), 16'd0);
        end
        complete_ok(0, 1'b1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16, the maximum number of cycles waited for mem_ready before a bus error.
REQ-002 SHALL have clk  input  1  clock, all state on rising edge.
REQ-003 SHALL have reset  input  1  reset, synchronous, active-high.
REQ-004 SHALL have run  input  1  fetch enable; while 0, no new fetch starts.
REQ-005 SHALL have flush  input  1  redirect strobe; an external unit loads the PC in the same cycle.
REQ-006 SHALL have pc_in  input  16  current PC value (ungated PC register output).
REQ-007 SHALL have mem_rd  output  1  memory read request.
REQ-008 SHALL have mem_addr  output  16  read address.
REQ-009 SHALL have mem_ready  input  1  read data valid; completes the request.
REQ-010 SHALL have mem_rdata  input  16  read data.
REQ-011 SHALL have ir  output  16  instruction register.
REQ-012 SHALL have ir_valid  output  1  ir holds an instruction not yet consumed.
REQ-013 SHALL have ir_ack  input  1  downstream consumed ir.
REQ-014 SHALL have load_pc  output  1  PC load strobe to the PC stage.
REQ-015 SHALL have pc_sel  output  2  PC source select; constant 2'b00 (PC+2).
REQ-016 SHALL have bus_err  output  1  one-cycle fetch-timeout pulse.

Function
REQ-017 SHALL implement FSM states IDLE, ADDR, FETCH, DRAIN, HOLD.
REQ-018 IDLE: all strobes 0; run=1 -> ADDR.
REQ-019 ADDR (1 cycle): addr_q <= pc_in; run=1 -> FETCH, run=0 -> IDLE.
REQ-020 FETCH: mem_rd=1, mem_addr=addr_q held stable; mem_ready=1 -> ir <= mem_rdata, load_pc=1 for that cycle only, -> HOLD.
REQ-021 HOLD: ir_valid=1; ir_ack=1 -> ADDR if run=1, else IDLE; HOLD lasts >=1 cycle, so pc_in reflects PC+2 at ADDR.
REQ-022 flush in ADDR or HOLD -> ADDR next cycle; ir_valid deasserts next cycle; flush takes priority over ir_ack.
REQ-023 flush in FETCH without mem_ready -> DRAIN; DRAIN keeps mem_rd=1 and mem_addr unchanged until mem_ready, then discards data (no ir write, no load_pc) -> ADDR.
REQ-024 flush coincident with mem_ready in FETCH: data discarded, load_pc=0, -> ADDR.
REQ-025 flush in DRAIN: no additional effect.
REQ-026 flush in IDLE: ignored.
REQ-027 run=0 never aborts FETCH/DRAIN; a transaction always completes before IDLE.
REQ-028 mem_rd SHALL be 1 only in FETCH and DRAIN; mem_addr=addr_q at all times.
REQ-029 ir SHALL change only per REQ-020; it holds its value outside FETCH completion.
REQ-030 pc_sel SHALL be 2'b00 in every cycle.

Reset
REQ-031 reset=1 at a clock edge: state=IDLE, addr_q=0, ir=0, timeout counter=0, regardless of current state, including mid-transaction.
REQ-032 While in reset and the cycle after: mem_rd=0, ir_valid=0, load_pc=0, bus_err=0, mem_addr=0x0000.

Configuration
REQ-033 Macro FETCH_TIMEOUT_EN defined: a counter clears on entry to FETCH/DRAIN and increments each cycle without mem_ready; at count TIMEOUT_CYCLES the unit drops mem_rd, pulses bus_err for 1 cycle, -> IDLE, no ir write, no load_pc.
REQ-034 FETCH_TIMEOUT_EN undefined: no counter; wait for mem_ready unbounded; bus_err tied 0; port list unchanged.

Verification
REQ-035 reset, pc_in=0x0000, run=1, mem_ready 2 cycles after mem_rd, rdata=0x1234 -> mem_addr=0x0000, ir=0x1234, ir_valid=1, single load_pc pulse.
REQ-036 Back-to-back fetches, ir_ack 1 cycle after ir_valid, pc_in follows PC+2 -> mem_addr 0x0000, 0x0002, 0x0004; exactly one load_pc per fetch.
REQ-037 flush while FETCH pending, pc_in=0x3000 -> mem_rd held until mem_ready, data dropped, no load_pc, next mem_addr=0x3000.
REQ-038 flush and ir_ack same cycle in HOLD -> ir_valid drops, next fetch uses redirected pc_in, ir_ack ignored.
REQ-039 FETCH_TIMEOUT_EN, TIMEOUT_CYCLES=16, mem_ready never asserted -> mem_rd high 16 cycles, bus_err 1-cycle pulse, IDLE, ir unchanged.
REQ-040 reset asserted in FETCH -> next cycle mem_rd=0, ir=0, ir_valid=0; fetch restarts at pc_in after release with run=1.
